unary_mac_sequencer: RTL

Sequencer that drives one shared `unary_shift_multiplier` with a stream of binary operand pairs and accumulates its unary output into a binary dot-product result. It accepts operand pairs over a valid/ready handshake and converts each operand to a unary burst: value N becomes N consecutive ones. It then lets the multiplier drain, counts `out` pulses into an accumulator, and presents the sum when the pair tagged `last` completes. It sits between the binary MAC front end and the unary multiplier datapath; the multiplier is instantiated by the parent, not inside this block.

---
 rtl/unary_mac_pkg.sv | 17 +
 rtl/unary_stream_gen.sv | 60 ++++++
 rtl/unary_mac_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/unary_mac_pkg.sv
// Shared types and default sizing for the unary MAC sequencer.
// Pure declarations: no logic, no latency, no flow control.
// Backpressure: not applicable.
package unary_mac_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    EMIT   = 2'd3
  } mac_state_t;

  localparam int DEF_BIN_BITS     = 4;
  localparam int DEF_ACC_BITS     = 12;
  localparam int DEF_DRAIN_CYCLES = 260;

endpackage

// File: rtl/unary_stream_gen.sv
// Binary-to-unary burst generator: operand N becomes N contiguous ones on its stream.
// Latency: first one appears the cycle after load; burst spans max(a,b) cycles.
// Backpressure: none; load is only pulsed by the sequencer while idle.
module unary_stream_gen
  import unary_mac_pkg::*;
#(
  parameter int BIN_BITS = DEF_BIN_BITS
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [BIN_BITS-1:0] a,
  input  logic [BIN_BITS-1:0] b,
  output logic                stream_a,
  output logic                stream_b,
  output logic                done
);

  logic [BIN_BITS-1:0] a_q;
  logic [BIN_BITS-1:0] b_q;
  logic [BIN_BITS-1:0] len_q;
  logic [BIN_BITS-1:0] cnt;
  logic [BIN_BITS-1:0] cnt_nxt;
  logic                active;

  assign cnt_nxt = cnt + 1'b1;
  // cnt indexes the stream cycle currently on the outputs; done marks the last one.
  assign done    = active && (cnt == len_q - 1'b1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      len_q    <= '0;
      cnt      <= '0;
      active   <= 1'b0;
      stream_a <= 1'b0;
      stream_b <= 1'b0;
    end else if (load) begin
      a_q      <= a;
      b_q      <= b;
      len_q    <= (a > b) ? a : b;
      cnt      <= '0;
      active   <= (a != '0) || (b != '0);
      stream_a <= (a != '0);
      stream_b <= (b != '0);
    end else if (active) begin
      if (done) begin
        active   <= 1'b0;
        stream_a <= 1'b0;
        stream_b <= 1'b0;
      end else begin
        cnt      <= cnt_nxt;
        stream_a <= (cnt_nxt < a_q);
        stream_b <= (cnt_nxt < b_q);
      end
    end
  end

endmodule

// File: rtl/unary_mac_sequencer.sv
// Feeds operand pairs as unary bursts to an external multiplier and accumulates its pulses.
// Latency: 1 + max(A,B) + drain window per pair; result one cycle after the last pair drains.
// Backpressure: in_ready low while a pair is in flight; result held until acc_ready. Option: UNARY_MAC_EARLY_DONE_EN.
module unary_mac_sequencer
  import unary_mac_pkg::*;
#(
  parameter int BIN_BITS     = DEF_BIN_BITS,
  parameter int ACC_BITS     = DEF_ACC_BITS,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_BITS-1:0] a_bin,
  input  logic [BIN_BITS-1:0] b_bin,
  input  logic                in_last,
  output logic                mult_in_a,
  output logic                mult_in_b,
  input  logic                mult_out,
  input  logic                mult_zero,
  output logic                acc_valid,
  input  logic                acc_ready,
  output logic [ACC_BITS-1:0] acc_out,
  output logic                acc_sat,
  output logic                busy
);

  localparam int                DW         = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [ACC_BITS-1:0] ACC_MAX  = {ACC_BITS{1'b1}};

  mac_state_t    state;
  logic          last_q;
  logic [DW-1:0] drain_cnt;
  logic          load;
  logic          gen_done;
  logic          drain_exit;

  assign load = (state == IDLE) && in_valid && in_ready;

`ifdef UNARY_MAC_EARLY_DONE_EN
  // The first drain cycle is skipped so the multiplier can register the stream tail.
  assign drain_exit = (drain_cnt == DRAIN_LAST) || (mult_zero && (drain_cnt != '0));
`else
  logic zero_unused;
  assign zero_unused = mult_zero;
  assign drain_exit  = (drain_cnt == DRAIN_LAST);
`endif

  unary_stream_gen #(
    .BIN_BITS (BIN_BITS)
  ) u_stream_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .a        (a_bin),
    .b        (b_bin),
    .stream_a (mult_in_a),
    .stream_b (mult_in_b),
    .done     (gen_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      acc_valid <= 1'b0;
      busy      <= 1'b0;
      last_q    <= 1'b0;
      drain_cnt <= '0;
      acc_out   <= '0;
      acc_sat   <= 1'b0;
    end else begin
      if (((state == STREAM) || (state == DRAIN)) && mult_out) begin
        if (acc_out == ACC_MAX) acc_sat <= 1'b1;
        else                    acc_out <= acc_out + 1'b1;
      end

      case (state)
        IDLE: begin
          if (load) begin
            last_q    <= in_last;
            drain_cnt <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= ((a_bin == '0) && (b_bin == '0)) ? DRAIN : STREAM;
          end
        end
        STREAM: begin
          if (gen_done) state <= DRAIN;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_exit) begin
            if (last_q) begin
              state     <= EMIT;
              acc_valid <= 1'b1;
            end else begin
              state    <= IDLE;
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end
          end
        end
        EMIT: begin
          if (acc_ready) begin
            acc_out   <= '0;
            acc_sat   <= 1'b0;
            acc_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
